// File: rtl/cache_line_access_ctrl.sv
// Shares the cache line RAM write port between a 4-beat line fill and word stores, and issues load reads.
// Latency: writes reach the RAM in the handshake cycle; load data returns two cycles after acceptance.
// Backpressure: fills beat stores except when starvation forces a store; loads are refused on line hazards only.
module cache_line_access_ctrl #(
    parameter int unsigned P_STARVE_LIMIT = 2
) (
    input  logic         iCLOCK,
    input  logic         inRESET,
    input  logic         iFILL_VALID,
    output logic         oFILL_READY,
    input  logic [3:0]   iFILL_ENTRY,
    input  logic [127:0] iFILL_DATA,
    output logic         oFILL_DONE,
    input  logic         iST_VALID,
    output logic         oST_READY,
    input  logic [3:0]   iST_ENTRY,
    input  logic [3:0]   iST_WORD,
    input  logic [3:0]   iST_MASK,
    input  logic [31:0]  iST_DATA,
    input  logic         iLD_VALID,
    output logic         oLD_READY,
    input  logic [3:0]   iLD_ENTRY,
    output logic         oLD_VALID,
    output logic [511:0] oLD_DATA,
    output logic         oRAM_WREN,
    output logic [3:0]   oRAM_WRADDR,
    output logic [63:0]  oRAM_BYTEENA,
    output logic [511:0] oRAM_DATA,
    output logic [3:0]   oRAM_RDADDR,
    input  logic [511:0] iRAM_Q
);

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } fill_state_t;

    localparam logic [3:0] STARVE_LIMIT = 4'(P_STARVE_LIMIT);

    fill_state_t  state_q, state_d;
    logic [3:0]   lock_entry_q, lock_entry_d;
    logic [1:0]   beat_q, beat_d;
    logic [3:0]   starve_q, starve_d;
    logic         done_q, done_d;
    logic         ld_v1_q, ld_v2_q;
    logic [511:0] ld_data_q;

    logic         in_burst;
    logic         st_elig;
    logic         st_force;
    logic         fill_go;
    logic         st_go;
    logic         ld_go;
    logic [1:0]   fill_beat;
    logic [3:0]   wr_addr;

    assign in_burst = (state_q == ST_BURST);

    // A store to the line being filled would be overwritten by later beats, so it waits for the fill.
    assign st_elig  = iST_VALID && !(in_burst && (iST_ENTRY == lock_entry_q));
    assign st_force = st_elig && (starve_q == STARVE_LIMIT);

    assign oFILL_READY = inRESET && !st_force;
    assign oST_READY   = inRESET && st_elig && (st_force || !iFILL_VALID);

    assign fill_go = iFILL_VALID && oFILL_READY;
    assign st_go   = iST_VALID && oST_READY;

    assign fill_beat = in_burst ? beat_q : 2'd0;
    assign wr_addr   = fill_go ? (in_burst ? lock_entry_q : iFILL_ENTRY) : iST_ENTRY;

    assign oRAM_WREN    = fill_go || st_go;
    assign oRAM_WRADDR  = wr_addr;
    assign oRAM_BYTEENA = fill_go ? (64'hFFFF << {fill_beat, 4'b0000})
                                  : (64'(iST_MASK) << {iST_WORD, 2'b00});
    assign oRAM_DATA    = fill_go ? {4{iFILL_DATA}} : {16{iST_DATA}};

    // Same-cycle write to the read line is refused so the read returns post-write data next cycle.
    assign oLD_READY = inRESET
                    && !(in_burst && (iLD_ENTRY == lock_entry_q))
                    && !(oRAM_WREN && (wr_addr == iLD_ENTRY));
    assign ld_go     = iLD_VALID && oLD_READY;

    assign oRAM_RDADDR = iLD_ENTRY;
    assign oLD_VALID   = ld_v2_q;
    assign oLD_DATA    = ld_data_q;
    assign oFILL_DONE  = done_q;

    always_comb begin
        state_d      = state_q;
        lock_entry_d = lock_entry_q;
        beat_d       = beat_q;
        done_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fill_go) begin
                    state_d      = ST_BURST;
                    lock_entry_d = iFILL_ENTRY;
                    beat_d       = 2'd1;
                end
            end
            ST_BURST: begin
                if (fill_go) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (st_go || !st_elig) begin
            starve_d = 4'd0;
        end else if (fill_go) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q      <= ST_IDLE;
            lock_entry_q <= 4'd0;
            beat_q       <= 2'd0;
            starve_q     <= 4'd0;
            done_q       <= 1'b0;
            ld_v1_q      <= 1'b0;
            ld_v2_q      <= 1'b0;
            ld_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            lock_entry_q <= lock_entry_d;
            beat_q       <= beat_d;
            starve_q     <= starve_d;
            done_q       <= done_d;
            ld_v1_q      <= ld_go;
            ld_v2_q      <= ld_v1_q;
            if (ld_v1_q) begin
                ld_data_q <= iRAM_Q;
            end
        end
    end

endmodule
